// File: rtl/pingpong_bank_ctrl.sv
// pingpong_bank_ctrl: handshaked two-bank ping-pong scheduler with per-bank full flags and block lengths
module pingpong_bank_ctrl #(
    parameter int DEPTH_W = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_valid,
    input  logic               wr_last,
    output logic               wr_ready,
    output logic               wr_en,
    output logic               wr_sel,
    output logic [DEPTH_W-1:0] wr_addr,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic               rd_en,
    output logic               rd_sel,
    output logic [DEPTH_W-1:0] rd_addr,
    output logic               rd_last,
    output logic [DEPTH_W:0]   rd_len,
    output logic [1:0]         full_cnt
);
    logic [1:0]       full;
    logic [DEPTH_W:0] len_a, len_b, cur_len;
    logic             wr_close, rd_drain;
    logic [1:0]       wr_mask, rd_mask;

    assign wr_ready = ~full[wr_sel];
    assign rd_valid = full[rd_sel];
    assign wr_en    = wr_valid & wr_ready;
    assign rd_en    = rd_valid & rd_ready;
    assign cur_len  = rd_sel ? len_b : len_a;
    assign rd_last  = rd_valid & ({1'b0, rd_addr} == cur_len - 1'b1);
    assign rd_len   = rd_valid ? cur_len : '0;
    assign full_cnt = {full[1] & full[0], full[1] ^ full[0]};
    assign wr_close = wr_en & (wr_last | (&wr_addr));
    assign rd_drain = rd_en & rd_last;
    assign wr_mask  = wr_close ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
    assign rd_mask  = rd_drain ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full    <= '0;
            len_a   <= '0;
            len_b   <= '0;
            wr_sel  <= 1'b0;
            wr_addr <= '0;
            rd_sel  <= 1'b0;
            rd_addr <= '0;
        end else begin
            full <= (full | wr_mask) & ~rd_mask;
            if (wr_en) begin
                wr_addr <= wr_close ? '0 : wr_addr + 1'b1;
                wr_sel  <= wr_sel ^ wr_close;
            end
            if (wr_close && !wr_sel) len_a <= {1'b0, wr_addr} + 1'b1;
            if (wr_close && wr_sel) len_b <= {1'b0, wr_addr} + 1'b1;
            if (rd_en) begin
                rd_addr <= rd_drain ? '0 : rd_addr + 1'b1;
                rd_sel  <= rd_sel ^ rd_drain;
            end
        end
    end
endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// tb_pingpong_bank_ctrl: random and directed stimulus checked against a block-queue model
module tb_pingpong_bank_ctrl;
    localparam int DW = 6;
    localparam int DEPTH = 1 << DW;

    logic clk = 0, reset_n = 0, wr_valid = 0, wr_last = 0, rd_ready = 0;
    logic wr_ready, wr_en, wr_sel, rd_valid, rd_en, rd_sel, rd_last;
    logic [DW-1:0] wr_addr, rd_addr;
    logic [DW:0] rd_len;
    logic [1:0] full_cnt;

    int errors = 0, checks = 0;
    int q[$];
    int closed = 0, drained = 0, waddr = 0, raddr = 0;
    bit e_wr_ready, e_wr_en, e_rd_valid, e_rd_en, e_rd_last;
    int e_rd_len;

    pingpong_bank_ctrl #(.DEPTH_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_last(wr_last),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_addr(rd_addr), .rd_last(rd_last), .rd_len(rd_len), .full_cnt(full_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // Closed blocks form a FIFO of lengths; bank indices follow from close/drain counts.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            closed = 0; drained = 0; waddr = 0; raddr = 0;
        end else begin
            e_wr_ready = q.size() < 2;
            e_rd_valid = q.size() > 0;
            e_wr_en    = wr_valid && e_wr_ready;
            e_rd_en    = rd_ready && e_rd_valid;
            e_rd_len   = e_rd_valid ? q[0] : 0;
            e_rd_last  = e_rd_valid && (raddr == q[0] - 1);
            chk("wr_ready", 32'(wr_ready), 32'(e_wr_ready));
            chk("wr_en",    32'(wr_en),    32'(e_wr_en));
            chk("wr_sel",   32'(wr_sel),   32'(closed % 2));
            chk("wr_addr",  32'(wr_addr),  32'(waddr));
            chk("rd_valid", 32'(rd_valid), 32'(e_rd_valid));
            chk("rd_en",    32'(rd_en),    32'(e_rd_en));
            chk("rd_sel",   32'(rd_sel),   32'(drained % 2));
            chk("rd_addr",  32'(rd_addr),  32'(raddr));
            chk("rd_last",  32'(rd_last),  32'(e_rd_last));
            chk("rd_len",   32'(rd_len),   32'(e_rd_len));
            chk("full_cnt", 32'(full_cnt), 32'(q.size()));
            if (e_rd_en) begin
                if (e_rd_last) begin
                    void'(q.pop_front());
                    drained++;
                    raddr = 0;
                end else raddr++;
            end
            if (e_wr_en) begin
                if (wr_last || waddr == DEPTH - 1) begin
                    q.push_back(waddr + 1);
                    closed++;
                    waddr = 0;
                end else waddr++;
            end
        end
    end

    task automatic step(input bit wv, input bit wl, input bit rr);
        @(posedge clk);
        #1;
        wr_valid = wv; wr_last = wl; rd_ready = rr;
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #3;
        reset_n = 0; wr_valid = 0; wr_last = 0; rd_ready = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    initial begin
        #1;
        chk("init_wr_ready", 32'(wr_ready), 1);
        chk("init_rd_valid", 32'(rd_valid), 0);
        chk("init_full_cnt", 32'(full_cnt), 0);
        chk("init_rd_len",   32'(rd_len),   0);
        @(posedge clk);
        #1;
        reset_n = 1;

        repeat (17) step(1, 0, 0);
        step(0, 0, 0);
        chk("pre_rst_wr_addr", 32'(wr_addr), 17);
        #2;
        reset_n = 0;
        #1;
        chk("arst_wr_ready", 32'(wr_ready), 1);
        chk("arst_wr_addr",  32'(wr_addr),  0);
        chk("arst_wr_sel",   32'(wr_sel),   0);
        chk("arst_rd_valid", 32'(rd_valid), 0);
        chk("arst_full_cnt", 32'(full_cnt), 0);
        @(posedge clk);
        #1;
        reset_n = 1;

        repeat (DEPTH) step(1, 0, 0);
        step(0, 0, 0);
        chk("full_wr_sel",   32'(wr_sel),   1);
        chk("full_full_cnt", 32'(full_cnt), 1);
        chk("full_rd_valid", 32'(rd_valid), 1);
        chk("full_rd_len",   32'(rd_len),   64);
        repeat (DEPTH) step(0, 0, 1);
        step(0, 0, 0);
        chk("drain_rd_sel",   32'(rd_sel),   1);
        chk("drain_full_cnt", 32'(full_cnt), 0);

        rst_pulse();
        repeat (4) step(1, 0, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        chk("part_rd_len",  32'(rd_len),  5);
        chk("part_wr_sel",  32'(wr_sel),  1);
        chk("part_wr_addr", 32'(wr_addr), 0);
        step(1, 0, 1);
        repeat (6) step(0, 0, 1);

        rst_pulse();
        repeat (2 * DEPTH) step(1, 0, 0);
        repeat (4) step(1, 0, 0);
        chk("bp_full_cnt", 32'(full_cnt), 2);
        chk("bp_wr_ready", 32'(wr_ready), 0);
        chk("bp_wr_addr",  32'(wr_addr),  0);
        repeat (DEPTH) step(0, 0, 1);
        step(0, 0, 0);
        chk("bp_refill_ready", 32'(wr_ready), 1);
        chk("bp_refill_sel",   32'(wr_sel),   0);

        rst_pulse();
        repeat (1000) step(1, $urandom_range(0, 15) == 0, 1);
        repeat (200) step(0, 0, 1);
        chk("stream_full_cnt", 32'(full_cnt), 0);

        rst_pulse();
        repeat (40) step(1, 1, 1);
        repeat (10) step(1, 1, 0);
        repeat (10) step(1, 1, $urandom_range(0, 1));
        step(0, 0, 0);
        step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pingpong_bank_ctrl.md
# pingpong_bank_ctrl

Sequences a two-bank (A/B) ping-pong block buffer between one producer and one consumer in the kernel datapath. Tracks full/empty state and fill length per bank, steers producer writes into the free bank and consumer reads out of the filled bank, and toggles each side's bank select independently. It replaces a free-running select toggle with a handshaked scheduler, so neither side can overrun or underrun a bank.

## Interface

- DEPTH_W, 6, log2 of words per bank; bank depth = 2^DEPTH_W.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset; clears all state immediately.
- wr_valid  in  1  producer presents a word this cycle.
- wr_last  in  1  qualifies wr_valid; the word closes the current block early (partial block).
- wr_ready  out  1  current write bank is empty and accepting.
- wr_en  out  1  bank RAM write strobe = wr_valid & wr_ready.
- wr_sel  out  1  bank being written (0 = A, 1 = B).
- wr_addr  out  DEPTH_W  word address within the write bank.
- rd_ready  in  1  consumer accepts a beat this cycle.
- rd_valid  out  1  current read bank holds a complete block.
- rd_en  out  1  bank RAM read strobe = rd_valid & rd_ready.
- rd_sel  out  1  bank being read (0 = A, 1 = B).
- rd_addr  out  DEPTH_W  word address within the read bank.
- rd_last  out  1  rd_valid and rd_addr is the final word of the block.
- rd_len  out  DEPTH_W+1  word count of the block in the read bank; 0 when rd_valid = 0.
- full_cnt  out  2  number of full banks (0..2).

## Operation

- State: full[1:0], len_a/len_b (DEPTH_W+1 bits each), wr_sel, wr_addr, rd_sel, rd_addr. All registered.
- Reset values: full = 00, len = 0, wr_sel = 0, wr_addr = 0, rd_sel = 0, rd_addr = 0; hence wr_ready = 1, rd_valid = 0, rd_last = 0, rd_len = 0, full_cnt = 0, wr_en = rd_en = 0.
- wr_ready = ~full[wr_sel]; rd_valid = full[rd_sel]. Neither depends on any input combinationally.
- Write beat (wr_en = 1): if wr_addr = 2^DEPTH_W - 1 or wr_last = 1, block closes: full[wr_sel] <= 1, len[wr_sel] <= wr_addr + 1, wr_sel <= ~wr_sel, wr_addr <= 0. Otherwise wr_addr <= wr_addr + 1.
- wr_last without wr_valid is ignored. wr_valid while wr_ready = 0 is ignored (producer must hold).
- Read beat (rd_en = 1): if rd_last, block drains: full[rd_sel] <= 0, rd_sel <= ~rd_sel, rd_addr <= 0. Otherwise rd_addr <= rd_addr + 1.
- rd_last = rd_valid & (rd_addr = len[rd_sel] - 1). Block of length 1 asserts rd_last on its first beat.
- Simultaneous close (write side) and drain (read side) in one cycle always target different banks (write needs empty, read needs full); both updates apply. full_cnt unchanged in that cycle.
- Length arithmetic in DEPTH_W+1 bits; full block length = 2^DEPTH_W, no wrap.
- wr_addr and rd_addr never exceed 2^DEPTH_W - 1; counters reset to 0 at every bank switch, never wrap in place.
- Blocks are read strictly in write order: A, B, A, B, ...

## Timing

- Write-to-read latency: block closes on edge N -> rd_valid = 1 from cycle N+1 (if rd_sel points at it).
- Drain-to-refill latency: block drains on edge N -> wr_ready for that bank = 1 from cycle N+1.
- Sustained throughput: one write and one read per cycle with both banks cycling; no bubble at bank switch on either side.
- Bank RAM read data lags rd_en by the RAM latency; the consumer handles the alignment, not this block.
- reset_n assertion mid-block: all state cleared asynchronously; partial and full blocks discarded; outputs take reset values without waiting for clk. Deassertion synchronised externally.

## Test plan

- Reset: reset_n = 0 mid-write at wr_addr = 17 -> wr_ready = 1, wr_addr = 0, wr_sel = 0, rd_valid = 0, full_cnt = 0 with no clock edge.
- Full block, DEPTH_W = 6: 64 consecutive writes, rd_ready = 0 -> after the 64th, wr_sel = 1, full_cnt = 1, rd_valid = 1, rd_len = 64; 64 reads -> rd_last only on rd_addr = 63, then rd_sel = 1, full_cnt = 0.
- Partial block: 5 writes with wr_last on the 5th -> rd_len = 5, rd_last on rd_addr = 4; next write lands at wr_sel = 1, wr_addr = 0.
- Backpressure: fill A and B (128 writes), rd_ready = 0 -> wr_ready = 0, full_cnt = 2, further wr_valid produces no wr_en and no address change; one full drain of A -> wr_ready = 1 on the next cycle with wr_sel = 0.
- Concurrent streaming: wr_valid = rd_ready = 1 continuously for 1000 cycles with random wr_last -> every block read once in order A/B alternating, lengths match written counts, no beat lost or duplicated.
- Length-1 blocks: wr_valid & wr_last every cycle -> each block rd_len = 1, rd_last on first read beat, banks alternate every cycle.
